// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-organised data memory.
// Optional misalignment trap: define LSU_MISALIGN_CHECK_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RMW,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [1:0]  lat_off;
    logic [1:0]  lat_width;
    logic        lat_zext;
    logic [15:0] lat_wdata;
    logic [31:0] lat_addr;

    logic        accept;
    logic        req_word;
    logic        req_misal;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        unused_ok;

    assign req_word  = sign_mask[1];
    assign unused_ok = sign_mask[3];

`ifdef LSU_MISALIGN_CHECK_EN
    // Halfword must sit on an even byte, word on offset 0.
    always_comb begin
        req_misal = 1'b0;
        if (sign_mask[1])
            req_misal = (addr[1:0] != 2'b00);
        else if (sign_mask[0])
            req_misal = addr[0];
    end
`else
    assign req_misal = 1'b0;
`endif

    // Lane select and extension of the returned memory word.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = mem_read_data[{lat_off, 3'b000} +: 8];
        h = mem_read_data[{lat_off[1], 4'b0000} +: 16];
        if (lat_width[1])
            load_val = mem_read_data;
        else if (lat_width[0])
            load_val = lat_zext ? {16'h0, h} : {{16{h[15]}}, h};
        else
            load_val = lat_zext ? {24'h0, b} : {{24{b[7]}}, b};
    end

    // Merge latched store lanes into the fetched word.
    always_comb begin
        merged = mem_read_data;
        if (lat_width[0])
            merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
        else
            merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    end

    // Next-state and strobe decode; strobes blocked while in reset.
    always_comb begin
        state_nx       = state;
        stall          = 1'b0;
        misaligned     = 1'b0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        mem_write_data = write_data;
        accept         = 1'b0;
        mem_addr       = lat_addr;
        unique case (state)
            IDLE: begin
                mem_addr = {2'b00, addr[31:2]};
                if (rst_n && (memwrite || memread)) begin
                    if (req_misal) begin
                        misaligned = 1'b1;
                    end else if (memwrite) begin
                        if (req_word) begin
                            mem_memwrite = 1'b1;
                        end else begin
                            mem_memread = 1'b1;
                            stall       = 1'b1;
                            accept      = 1'b1;
                            state_nx    = RMW;
                        end
                    end else begin
                        mem_memread = 1'b1;
                        stall       = 1'b1;
                        accept      = 1'b1;
                        state_nx    = LOAD;
                    end
                end
            end
            LOAD: begin
                stall    = 1'b1;
                state_nx = DONE;
            end
            RMW: begin
                stall          = 1'b1;
                mem_memwrite   = rst_n;
                mem_write_data = merged;
                state_nx       = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Request fields captured when a multi-cycle access starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_off   <= 2'b00;
            lat_width <= 2'b00;
            lat_zext  <= 1'b0;
            lat_wdata <= 16'h0;
            lat_addr  <= 32'h0;
        end else if (accept) begin
            lat_off   <= addr[1:0];
            lat_width <= sign_mask[1:0];
            lat_zext  <= sign_mask[2];
            lat_wdata <= write_data[15:0];
            lat_addr  <= {2'b00, addr[31:2]};
        end
    end

    // Load result register, updated only when a load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            read_data <= 32'h0;
        else if (state == LOAD)
            read_data <= load_val;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Includes a synchronous word memory with one-cycle read latency.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        stall;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:4095];
    int rd_cnt;
    int wr_cnt;

    int checks;
    int errors;

    int          stalls;
    int          reads;
    int          writes;
    logic        timeout;
    logic [31:0] last_rd;
    logic [31:0] f_addr;
    logic [31:0] f_wdata;
    logic        f_mw;
    logic        f_mr;
    logic        f_stall;
    logic        f_mis;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr           (addr),
        .write_data     (write_data),
        .memwrite       (memwrite),
        .memread        (memread),
        .sign_mask      (sign_mask),
        .read_data      (read_data),
        .stall          (stall),
        .misaligned     (misaligned),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rd_cnt = 0;
        wr_cnt = 0;
    end

    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem[mem_addr[11:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_memread) begin
            mem_read_data <= mem[mem_addr[11:0]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic run_req(input logic we, input logic re,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m);
        int  r0;
        int  w0;
        logic done;
        memwrite   = we;
        memread    = re;
        addr       = a;
        write_data = wd;
        sign_mask  = m;
        r0     = rd_cnt;
        w0     = wr_cnt;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                f_addr  = mem_addr;
                f_wdata = mem_write_data;
                f_mw    = mem_memwrite;
                f_mr    = mem_memread;
                f_stall = stall;
                f_mis   = misaligned;
            end
            if (stall) begin
                stalls++;
            end else begin
                done    = 1'b1;
                last_rd = read_data;
            end
            @(posedge clk);
            #1;
        end
        timeout  = !done;
        memwrite = 1'b0;
        memread  = 1'b0;
        reads    = rd_cnt - r0;
        writes   = wr_cnt - w0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd got %h want 0", read_data);
        end
        checks++;
        if ({stall, misaligned, mem_memwrite, mem_memread} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                     {stall, misaligned, mem_memwrite, mem_memread});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_store;
        run_req(1'b1, 1'b0, 32'h400, 32'h8899AABB, 4'b0010);
        checks++;
        if ({f_mw, f_mr, f_stall} !== 3'b100) begin
            errors++;
            $display("FAIL wst_ctl got %b want 100", {f_mw, f_mr, f_stall});
        end
        checks++;
        if (f_addr !== 32'h100 || f_wdata !== 32'h8899AABB) begin
            errors++;
            $display("FAIL wst_bus got %h/%h want 100/8899aabb", f_addr, f_wdata);
        end
        run_req(1'b1, 1'b0, 32'h2000, 32'hDEADBEEF, 4'b0010);
        checks++;
        if (f_addr !== 32'h800 || !f_mw || f_stall || stalls != 0) begin
            errors++;
            $display("FAIL wst2 got a=%h mw=%b st=%0d want a=800 mw=1 st=0",
                     f_addr, f_mw, stalls);
        end
        checks++;
        if (writes != 1 || reads != 0) begin
            errors++;
            $display("FAIL wst2_cnt got w=%0d r=%0d want w=1 r=0", writes, reads);
        end
    endtask

    task automatic test_load_byte;
        run_req(1'b0, 1'b1, 32'h401, 32'h0, 4'b0000);
        checks++;
        if (timeout || stalls != 2 || f_addr !== 32'h100) begin
            errors++;
            $display("FAIL lb_tim got st=%0d a=%h want st=2 a=100", stalls, f_addr);
        end
        checks++;
        if (last_rd !== 32'hFFFFFFAA) begin
            errors++;
            $display("FAIL lb_s got %h want ffffffaa", last_rd);
        end
        checks++;
        if (reads != 1 || writes != 0) begin
            errors++;
            $display("FAIL lb_cnt got r=%0d w=%0d want r=1 w=0", reads, writes);
        end
        run_req(1'b0, 1'b1, 32'h401, 32'h0, 4'b0100);
        checks++;
        if (last_rd !== 32'h000000AA) begin
            errors++;
            $display("FAIL lb_z got %h want 000000aa", last_rd);
        end
        run_req(1'b0, 1'b1, 32'h403, 32'h0, 4'b0000);
        checks++;
        if (last_rd !== 32'hFFFFFF88) begin
            errors++;
            $display("FAIL lb_off3 got %h want ffffff88", last_rd);
        end
        run_req(1'b0, 1'b1, 32'h400, 32'h0, 4'b0000);
        checks++;
        if (last_rd !== 32'hFFFFFFBB) begin
            errors++;
            $display("FAIL lb_off0 got %h want ffffffbb", last_rd);
        end
    endtask

    task automatic test_load_half;
        run_req(1'b0, 1'b1, 32'h402, 32'h0, 4'b0001);
        checks++;
        if (last_rd !== 32'hFFFF8899 || stalls != 2) begin
            errors++;
            $display("FAIL lh_s got %h st=%0d want ffff8899 st=2", last_rd, stalls);
        end
        run_req(1'b0, 1'b1, 32'h400, 32'h0, 4'b0101);
        checks++;
        if (last_rd !== 32'h0000AABB) begin
            errors++;
            $display("FAIL lh_z got %h want 0000aabb", last_rd);
        end
    endtask

    task automatic test_load_word;
        run_req(1'b0, 1'b1, 32'h400, 32'h0, 4'b0010);
        checks++;
        if (last_rd !== 32'h8899AABB || stalls != 2) begin
            errors++;
            $display("FAIL lw got %h st=%0d want 8899aabb st=2", last_rd, stalls);
        end
        run_req(1'b0, 1'b1, 32'h2000, 32'h0, 4'b0011);
        checks++;
        if (last_rd !== 32'hDEADBEEF || f_addr !== 32'h800) begin
            errors++;
            $display("FAIL lw_w11 got %h a=%h want deadbeef a=800", last_rd, f_addr);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] prev;
        prev = read_data;
        run_req(1'b0, 1'b1, 32'h403, 32'h0, 4'b0101);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++;
        if (!f_mis || f_stall || f_mr || f_mw) begin
            errors++;
            $display("FAIL mis_ctl got m=%b s=%b r=%b w=%b want 1000",
                     f_mis, f_stall, f_mr, f_mw);
        end
        checks++;
        if (reads != 0 || writes != 0 || stalls != 0) begin
            errors++;
            $display("FAIL mis_cnt got r=%0d w=%0d st=%0d want 0",
                     reads, writes, stalls);
        end
        checks++;
        if (last_rd !== prev) begin
            errors++;
            $display("FAIL mis_rd got %h want %h", last_rd, prev);
        end
`else
        checks++;
        if (f_mis !== 1'b0) begin
            errors++;
            $display("FAIL mis_tied got %b want 0", f_mis);
        end
        checks++;
        if (last_rd !== 32'h00008899 || last_rd === prev) begin
            errors++;
            $display("FAIL lh_odd got %h want 00008899", last_rd);
        end
`endif
    endtask

    task automatic test_subword_store;
        logic [31:0] prev;
        prev = read_data;
        run_req(1'b1, 1'b0, 32'h402, 32'h00001234, 4'b0001);
        checks++;
        if (timeout || stalls != 2 || reads != 1 || writes != 1) begin
            errors++;
            $display("FAIL sh_tim got st=%0d r=%0d w=%0d want 2/1/1",
                     stalls, reads, writes);
        end
        checks++;
        if (last_rd !== prev) begin
            errors++;
            $display("FAIL sh_rd got %h want %h", last_rd, prev);
        end
        run_req(1'b0, 1'b1, 32'h400, 32'h0, 4'b0010);
        checks++;
        if (last_rd !== 32'h1234AABB) begin
            errors++;
            $display("FAIL sh_mem got %h want 1234aabb", last_rd);
        end
        run_req(1'b1, 1'b0, 32'h400, 32'hFFFFFF55, 4'b0000);
        checks++;
        if (stalls != 2 || writes != 1) begin
            errors++;
            $display("FAIL sb_tim got st=%0d w=%0d want 2/1", stalls, writes);
        end
        run_req(1'b0, 1'b1, 32'h400, 32'h0, 4'b0010);
        checks++;
        if (last_rd !== 32'h1234AA55) begin
            errors++;
            $display("FAIL sb_mem got %h want 1234aa55", last_rd);
        end
    endtask

    task automatic test_back_to_back;
        run_req(1'b0, 1'b1, 32'h401, 32'h0, 4'b0100);
        checks++;
        if (last_rd !== 32'h000000AA) begin
            errors++;
            $display("FAIL b2b_1 got %h want 000000aa", last_rd);
        end
        run_req(1'b0, 1'b1, 32'h402, 32'h0, 4'b0001);
        checks++;
        if (!f_stall || !f_mr || last_rd !== 32'h00001234) begin
            errors++;
            $display("FAIL b2b_2 got %h s=%b r=%b want 00001234 s=1 r=1",
                     last_rd, f_stall, f_mr);
        end
    endtask

    task automatic test_reset_rmw;
        int w0;
        memwrite   = 1'b1;
        addr       = 32'h400;
        write_data = 32'h00000077;
        sign_mask  = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (mem_memwrite !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rmw_ent got w=%b s=%b want 1/1", mem_memwrite, stall);
        end
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall, misaligned, mem_memwrite, mem_memread} !== 4'b0 ||
            read_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid got %b rd=%h want 0000 rd=0",
                     {stall, misaligned, mem_memwrite, mem_memread}, read_data);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL rst_wr got %0d writes want 0", wr_cnt - w0);
        end
        memwrite = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        run_req(1'b0, 1'b1, 32'h400, 32'h0, 4'b0010);
        checks++;
        if (last_rd !== 32'h1234AA55) begin
            errors++;
            $display("FAIL rst_mem got %h want 1234aa55", last_rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        memwrite   = 1'b0;
        memread    = 1'b0;
        sign_mask  = 4'b0;
        test_reset();
        test_word_store();
        test_load_byte();
        test_load_half();
        test_load_word();
        test_misalign();
        test_subword_store();
        test_back_to_back();
        test_reset_rmw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
